// File: rtl/count_call_arbiter.sv
// count_call_arbiter: round-robin scheduler sharing one `count` HLS component
// among NUM_REQ requesters. One call is in flight at a time.
//
// Ports:
//   clock, resetn          single rising-edge clock, synchronous active-low reset
//   req_valid/req_ready    per-requester call request; req_ready is a one-hot grant
//   rsp_valid/rsp_ready    per-requester result handshake; rsp_valid is one-hot
//   rsp_data               registered result, shared by all requesters
//   owner_id               index of the current or last granted requester
//   cnt_start/cnt_busy     component call interface (valid/stall)
//   cnt_done/cnt_stall     component return interface (valid/stall)
//   cnt_returndata         component result
//   call_count             completed response handshakes, wraps at 2^32
module count_call_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [ID_W-1:0]    owner_id,
  output logic               cnt_start,
  input  logic               cnt_busy,
  input  logic               cnt_done,
  output logic               cnt_stall,
  input  logic [DATA_W-1:0]  cnt_returndata,
  output logic [31:0]        call_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [31:0]         call_count_q, call_count_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_sel;
  int unsigned         scan_idx;

  // Round-robin pick: first pending request after the last granted index, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    scan_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_sel   = ID_W'(scan_idx);
      end
    end
  end

  // State register. call_count_q is loaded every cycle so it always follows its next value.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      owner_q      <= '0;
      rsp_data_q   <= '0;
      call_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rsp_data_q   <= rsp_data_d;
      call_count_q <= call_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rsp_data_d   = rsp_data_q;
    call_count_d = call_count_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          owner_d = grant_sel;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!cnt_busy) state_d = StWait;
      end
      StWait: begin
        if (cnt_done) begin
          rsp_data_d = cnt_returndata;
          state_d    = StResp;
        end
      end
      StResp: begin
        // Only the owner's ready bit completes the response.
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          call_count_d = call_count_q + 32'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: req_ready is the only path combinational from inputs.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == StIdle && grant_found) req_ready[grant_sel] = 1'b1;
    if (state_q == StResp) rsp_valid[owner_q] = 1'b1;
    cnt_start = (state_q == StIssue);
    cnt_stall = (state_q != StWait);
  end

  assign rsp_data   = rsp_data_q;
  assign owner_id   = owner_q;
  assign call_count = call_count_q;

endmodule

// File: doc/count_call_arbiter.md
# count_call_arbiter

Round-robin scheduler that shares one `count` HLS component among `NUM_REQ` requesters. It accepts one call request at a time, drives the component's call interface (`start`/`busy`), collects the result through the return interface (`done`/`stall`/`returndata`) and routes it back to the owning requester. It also keeps a running count of completed calls. It sits between the requesting logic and the single `count` instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 16. `ID_W` = clog2(`NUM_REQ`) is derived internally.
- `DATA_W`, default 32: width of `returndata` and `rsp_data`.

Ports:
- `clock`  in  1: single clock; all logic is rising-edge.
- `resetn`  in  1: reset is synchronous and active-low.
- `req_valid`  in  NUM_REQ: bit i = requester i wants a call. It is held until accepted.
- `req_ready`  out  NUM_REQ: one-hot; bit i high = request i accepted this cycle.
- `rsp_valid`  out  NUM_REQ: one-hot; result available for owner.
- `rsp_ready`  in  NUM_REQ: requester i consumes the result.
- `rsp_data`  out  DATA_W: registered result; shared by all requesters.
- `owner_id`  out  ID_W: index of the current or last granted requester.
- `cnt_start`  out  1: drives the component's `start` (call.valid).
- `cnt_busy`  in  1: the component's `busy` (call.stall).
- `cnt_done`  in  1: the component's `done` (return.valid).
- `cnt_stall`  out  1: drives the component's `stall` (return.stall).
- `cnt_returndata`  in  DATA_W: the component's `returndata`.
- `call_count`  out  32: number of completed calls (response handshakes).

## Operation
The state machine has four states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If any `req_valid` bit is set, select the first set bit scanning from `(last_grant+1) mod NUM_REQ` upward, with wrap.
  - Assert `req_ready[sel]` combinationally in the same cycle.
  - Register `owner_id`=sel and go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - `cnt_start`=1.
  - When `cnt_busy`=0 in the same cycle, the call is taken; go to WAIT.
  - Otherwise hold `cnt_start` high and stay in ISSUE.
- **WAIT**
  - `cnt_stall`=0.
  - When `cnt_done`=1, register `cnt_returndata` into `rsp_data` and go to RESP.
- **RESP**
  - `rsp_valid[owner_id]`=1.
  - When `rsp_ready[owner_id]`=1: set `last_grant`=`owner_id`, increment `call_count`, and go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.

Output and boundary rules:
- `cnt_stall` = 1 in every state except WAIT. Any `cnt_done` outside WAIT is therefore not consumed; the component holds it.
- Only one call is ever in flight.
- `req_ready`, `rsp_valid` and `cnt_start` are zero outside their own states.
- A requester that drops `req_valid` before it is accepted is simply skipped; this is not an error.
- `call_count` wraps from 0xFFFFFFFF to 0.
- `rsp_data` holds its value until the next capture.

Reset (`resetn`=0 at a clock edge):
- State returns to IDLE.
- `last_grant` = NUM_REQ-1, so requester 0 wins first.
- `owner_id`=0, `rsp_data`=0, `call_count`=0.
- `req_ready`=0, `rsp_valid`=0, `cnt_start`=0, `cnt_stall`=1.
- An in-flight call is abandoned. The `count` component is on the same `resetn`.

## Timing
- Request accepted at cycle T (IDLE) → `cnt_start` high at T+1.
- Call taken at cycle S (`cnt_busy`=0) → WAIT from S+1.
- `cnt_done` at cycle D → `rsp_valid` and `rsp_data` valid at D+1.
- Response handshake at cycle R → IDLE at R+1; the next `req_ready` can occur at R+1.
- Minimum arbiter overhead is 3 cycles plus the component latency.
- `req_ready` is combinational from `req_valid` and the state. All other outputs are registered or decoded from the state only.

## Test plan
- **Single call:** requester 2 raises `req_valid`; the model asserts `done` 5 cycles after start with returndata=0x2A.
  - Required: `req_ready`=0b0100 for one cycle, `cnt_start` on the next cycle.
  - Required: `rsp_valid`=0b0100 with `rsp_data`=0x2A; `call_count`=1 after `rsp_ready`.
- **Fairness:** all 4 requesters hold `req_valid` continuously for 8 calls.
  - Required: grant order 0,1,2,3,0,1,2,3; `call_count`=8.
- **Backpressure on both sides:** `cnt_busy` high for 3 cycles during ISSUE, and `rsp_ready` low for 4 cycles in RESP.
  - Required: `cnt_start` held for 4 cycles; `rsp_valid` and `rsp_data` stable.
  - Required: exactly one call is issued and no new grant occurs until the handshake.
- **Spurious done:** `cnt_done` pulsed while in IDLE.
  - Required: `cnt_stall`=1, no state change, `rsp_valid` stays 0.
- **Reset mid-WAIT:** `resetn`=0 for 1 cycle while in WAIT.
  - Required: all outputs at their reset values on the next cycle, and requester 0 is granted first afterwards.
- **Wrap:** force `call_count`=0xFFFFFFFF, then complete one call.
  - Required: `call_count`=0.
